// File: rtl/proc_defs.sv
// Shared execute-stage definitions: multdiv FSM state encoding and ALU opcodes.
// Latency: n/a (constants only).
// Backpressure: n/a.
package proc_defs;

  // multdiv_unit sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // ALU opcodes the DX-stage decoder turns into ctrl_MULT / ctrl_DIV pulses
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor, restore if negative.
// Latency: purely combinational.
// Backpressure: none; the caller sequences iterations.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Shifted partial remainder needs one extra bit; when the subtract fits the
  // true difference is below the divisor, so its low WIDTH bits are exact.
  always_comb begin
    trial = {rem_in, quo_in[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - divisor;
    fits  = (trial >= {1'b0, divisor});
    if (fits) begin
      rem_out = diff;
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) for the execute stage.
// Latency: WIDTH+1 edges from start to a one-cycle data_resultRDY pulse, for every op and exception case.
// Backpressure: none; busy stalls the pipeline, and a new start at any time aborts and restarts.
module multdiv_unit
  import proc_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state, next_state;
  logic [CW-1:0]    cnt;
  logic             start, last_step;

  // Shared datapath: acc/qreg/qm1 form the Booth product register in MUL and
  // hold remainder/quotient in DIV; mcand is multiplicand or divisor magnitude.
  logic [WIDTH-1:0] acc, qreg, mcand;
  logic             qm1;
  logic             sign_diff, div_zero, div_ovf;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] div_res;
  logic             mul_exc;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_step = (cnt == CW'(WIDTH));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state: a start wins from any state (multiply has priority), otherwise sequence
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        MUL:     next_state = last_step ? DONE : MUL;
        DIV:     next_state = last_step ? DONE : DIV;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register only
  always_comb begin
    busy           = (state != IDLE);
    data_resultRDY = (state == DONE);
  end

  // Booth step: the sum is kept one bit wider so that subtracting MIN does not
  // lose its sign; after the arithmetic shift the value fits WIDTH bits again.
  always_comb begin
    case ({qreg[0], qm1})
      2'b01:   booth_sum = {acc[WIDTH-1], acc} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {acc[WIDTH-1], acc} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {acc[WIDTH-1], acc};
    endcase
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (acc),
    .quo_in  (qreg),
    .divisor (mcand),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Result fix-up: product overflow when the high word is not the sign
  // extension of the low word; quotient sign and the two divide exceptions
  always_comb begin
    mul_exc = (acc != {WIDTH{qreg[WIDTH-1]}});
    if (div_zero)       div_res = '0;
    else if (div_ovf)   div_res = MIN_VAL;
    else if (sign_diff) div_res = -qreg;
    else                div_res = qreg;
  end

  // Datapath: latch on start, iterate WIDTH times, then capture the result on the way into DONE
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt            <= '0;
      acc            <= '0;
      qreg           <= '0;
      qm1            <= 1'b0;
      mcand          <= '0;
      sign_diff      <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      acc       <= '0;
      qm1       <= 1'b0;
      sign_diff <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero  <= (data_operandB == '0);
      div_ovf   <= (data_operandA == MIN_VAL) && (data_operandB == '1);
      if (ctrl_MULT) begin
        mcand <= data_operandA;
        qreg  <= data_operandB;
      end else begin
        mcand <= mag(data_operandB);
        qreg  <= mag(data_operandA);
      end
    end else if ((state == MUL) && !last_step) begin
      cnt  <= cnt + CW'(1);
      acc  <= booth_sum[WIDTH:1];
      qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
      qm1  <= qreg[0];
    end else if ((state == DIV) && !last_step) begin
      cnt  <= cnt + CW'(1);
      acc  <= rem_nxt;
      qreg <= quo_nxt;
    end else if (state == MUL) begin
      data_result    <= qreg;
      data_exception <= mul_exc;
    end else if (state == DIV) begin
      data_result    <= div_res;
      data_exception <= div_zero | div_ovf;
    end
  end

endmodule
